// File: rtl/gun_heat_manager_if.sv
// gun_heat_manager_if: groups the per-gun shoot request with the heat,
// lockout and fire-strobe outputs that go to the spawner and the HUD.
`default_nettype none

interface gun_heat_manager_if #(
  parameter int NUM_GUNS = 2,
  parameter int HEAT_W   = 4
);
  logic [NUM_GUNS-1:0]        shoot;
  logic [NUM_GUNS*HEAT_W-1:0] heat;
  logic [NUM_GUNS-1:0]        overheated;
  logic [NUM_GUNS-1:0]        fire_pulse;

  modport master (output shoot, input heat, input overheated, input fire_pulse);
  modport slave  (input shoot, output heat, output overheated, output fire_pulse);
endinterface

`default_nettype wire

// File: rtl/gun_heat_manager.sv
// ============================================================================
// gun_heat_manager
//   Per-gun saturating heat tracker driven by shared fire/cool prescalers,
//   with an optional overheat lockout (enable with `define GUN_HEAT_LOCKOUT_EN).
//   Rev 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module gun_heat_manager #(
  parameter int NUM_GUNS      = 2,
  parameter int HEAT_W        = 4,
  parameter int FIRE_TICKS    = 50_000_000,
  parameter int COOL_TICKS    = 100_000_000,
  parameter int RELEASE_LEVEL = 4
) (
  input  wire logic          clock,
  input  wire logic          reset,
  gun_heat_manager_if.slave  io_gun
);

  localparam logic [27:0]       c_FIRE_RELOAD = 28'(FIRE_TICKS - 1);
  localparam logic [27:0]       c_COOL_RELOAD = 28'(COOL_TICKS - 1);
  localparam logic [HEAT_W-1:0] c_HEAT_MAX    = {HEAT_W{1'b1}};

  if (NUM_GUNS < 1 || NUM_GUNS > 8 || FIRE_TICKS < 2 || COOL_TICKS < 2 ||
      FIRE_TICKS > 2**28 || COOL_TICKS > 2**28 ||
      RELEASE_LEVEL < 0 || RELEASE_LEVEL >= 2**HEAT_W - 1) begin : g_param_check
    $error("gun_heat_manager: parameter out of range");
  end

  logic [27:0] r_fire_cnt;
  logic [27:0] r_cool_cnt;
  logic        w_fire_tick;
  logic        w_cool_tick;

  assign w_fire_tick = (r_fire_cnt == 28'd0);
  assign w_cool_tick = (r_cool_cnt == 28'd0);

  // Prescalers free-run; shoot never touches them.
  always_ff @(posedge clock) begin
    if (reset || w_fire_tick) r_fire_cnt <= c_FIRE_RELOAD;
    else                      r_fire_cnt <= r_fire_cnt - 28'd1;
    if (reset || w_cool_tick) r_cool_cnt <= c_COOL_RELOAD;
    else                      r_cool_cnt <= r_cool_cnt - 28'd1;
  end

`ifdef GUN_HEAT_LOCKOUT_EN
  localparam logic [HEAT_W-1:0] c_RELEASE = HEAT_W'(RELEASE_LEVEL);
  typedef enum logic [0:0] {ST_READY = 1'b0, ST_LOCKED = 1'b1} state_t;
`endif

  logic [NUM_GUNS*HEAT_W-1:0] w_heat_all;
  logic [NUM_GUNS-1:0]        w_ovh_all;
  logic [NUM_GUNS-1:0]        w_pulse_all;

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_gun
    logic [HEAT_W-1:0] r_heat;
    logic [HEAT_W-1:0] w_heat_nxt;
    logic [HEAT_W-1:0] w_heat_inc;
    logic [HEAT_W-1:0] w_heat_dec;
    logic              r_pulse;
    logic              w_pulse_nxt;
    logic              w_shoot;

    assign w_shoot    = io_gun.shoot[g];
    assign w_heat_inc = (r_heat == c_HEAT_MAX) ? r_heat : r_heat + HEAT_W'(1);
    assign w_heat_dec = (r_heat == '0) ? r_heat : r_heat - HEAT_W'(1);

`ifdef GUN_HEAT_LOCKOUT_EN
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_state <= ST_READY;
        r_heat  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_heat  <= w_heat_nxt;
        r_pulse <= w_pulse_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_heat_nxt  = r_heat;
      w_pulse_nxt = 1'b0;
      case (r_state)
        ST_READY: begin
          // Fire wins over cool when both ticks land with shoot held.
          if (w_fire_tick && w_shoot) begin
            w_heat_nxt  = w_heat_inc;
            w_pulse_nxt = 1'b1;
            if (w_heat_inc == c_HEAT_MAX) w_state_nxt = ST_LOCKED;
          end else if (w_cool_tick && !w_shoot) begin
            w_heat_nxt = w_heat_dec;
          end
        end
        ST_LOCKED: begin
          if (w_cool_tick) begin
            w_heat_nxt = w_heat_dec;
            if (w_heat_dec <= c_RELEASE) w_state_nxt = ST_READY;
          end
        end
        default: w_state_nxt = ST_READY;
      endcase
    end

    assign w_ovh_all[g] = (r_state == ST_LOCKED);
`else
    always_ff @(posedge clock) begin
      if (reset) begin
        r_heat  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_heat  <= w_heat_nxt;
        r_pulse <= w_pulse_nxt;
      end
    end

    always_comb begin
      w_heat_nxt  = r_heat;
      w_pulse_nxt = 1'b0;
      if (w_fire_tick && w_shoot) begin
        w_heat_nxt  = w_heat_inc;
        w_pulse_nxt = 1'b1;
      end else if (w_cool_tick && !w_shoot) begin
        w_heat_nxt = w_heat_dec;
      end
    end

    assign w_ovh_all[g] = 1'b0;
`endif

    assign w_heat_all[g*HEAT_W +: HEAT_W] = r_heat;
    assign w_pulse_all[g]                 = r_pulse;
  end

  assign io_gun.heat       = w_heat_all;
  assign io_gun.overheated = w_ovh_all;
  assign io_gun.fire_pulse = w_pulse_all;

endmodule

`default_nettype wire

// File: tb/tb_gun_heat_manager.sv
// tb_gun_heat_manager: directed table of {shoot, cycle, expected outputs}
// rows plus hand sequences for reset-during-reset and mid-run reset.
`default_nettype none

module tb_gun_heat_manager;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gun_heat_manager_if #(.NUM_GUNS(2), .HEAT_W(4)) u_if ();

  gun_heat_manager #(
    .NUM_GUNS(2), .HEAT_W(4), .FIRE_TICKS(4), .COOL_TICKS(8), .RELEASE_LEVEL(4)
  ) u_dut (
    .clock  (clock),
    .reset  (reset),
    .io_gun (u_if)
  );

  typedef struct {
    bit         rst;
    int         cyc;
    logic [1:0] shoot;
    logic [3:0] h0;
    logic [3:0] h1;
    logic [1:0] ovh;
    logic [1:0] pulse;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  function automatic void add(bit rst, int c, logic [1:0] s, logic [3:0] h0, logic [3:0] h1,
                              logic [1:0] o, logic [1:0] p);
    vec_t v;
    v.rst = rst; v.cyc = c; v.shoot = s; v.h0 = h0; v.h1 = h1; v.ovh = o; v.pulse = p;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset(int n);
    reset      = 1'b1;
    u_if.shoot = 2'b00;
    repeat (n) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic expect_out(string tag, logic [3:0] h0, logic [3:0] h1, logic [1:0] o, logic [1:0] p);
    checks++;
    if (u_if.heat !== {h1, h0} || u_if.overheated !== o || u_if.fire_pulse !== p) begin
      failures++;
      $display("FAIL %s cyc=%0d: got heat1/heat0=%0d/%0d ovh=%b pulse=%b, want %0d/%0d ovh=%b pulse=%b",
               tag, cyc, u_if.heat[7:4], u_if.heat[3:0], u_if.overheated, u_if.fire_pulse,
               h1, h0, o, p);
    end
  endtask

  initial begin
    u_if.shoot = 2'b11;

    // Idle at zero, including across the first cool ticks.
    add(1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 8, 2'b00, 0, 0, 2'b00, 2'b00);
    add(0, 40, 2'b00, 0, 0, 2'b00, 2'b00);
    // Gun 0 held from cycle 0.
    add(1, 0, 2'b01, 0, 0, 2'b00, 2'b00);
    add(0, 3, 2'b01, 0, 0, 2'b00, 2'b00);
    add(0, 4, 2'b01, 1, 0, 2'b00, 2'b01);
    add(0, 5, 2'b01, 1, 0, 2'b00, 2'b00);
    add(0, 7, 2'b01, 1, 0, 2'b00, 2'b00);
    add(0, 8, 2'b01, 2, 0, 2'b00, 2'b01);
    add(0, 56, 2'b01, 14, 0, 2'b00, 2'b01);
    add(0, 59, 2'b01, 14, 0, 2'b00, 2'b00);
`ifdef GUN_HEAT_LOCKOUT_EN
    add(0, 60, 2'b01, 15, 0, 2'b01, 2'b01);
    add(0, 61, 2'b01, 15, 0, 2'b01, 2'b00);
    add(0, 64, 2'b01, 14, 0, 2'b01, 2'b00);
    add(0, 72, 2'b01, 13, 0, 2'b01, 2'b00);
    add(0, 136, 2'b01, 5, 0, 2'b01, 2'b00);
    add(0, 143, 2'b01, 5, 0, 2'b01, 2'b00);
    add(0, 144, 2'b01, 4, 0, 2'b00, 2'b00);
    add(0, 148, 2'b01, 5, 0, 2'b00, 2'b01);
    add(0, 152, 2'b01, 6, 0, 2'b00, 2'b01);
`else
    add(0, 60, 2'b01, 15, 0, 2'b00, 2'b01);
    add(0, 61, 2'b01, 15, 0, 2'b00, 2'b00);
    add(0, 64, 2'b01, 15, 0, 2'b00, 2'b01);
    add(0, 100, 2'b01, 15, 0, 2'b00, 2'b01);
    add(0, 101, 2'b00, 15, 0, 2'b00, 2'b00);
    add(0, 103, 2'b00, 15, 0, 2'b00, 2'b00);
    add(0, 104, 2'b00, 14, 0, 2'b00, 2'b00);
    add(0, 112, 2'b00, 13, 0, 2'b00, 2'b00);
`endif
    // Both guns; cycles 7 and 15 carry fire and cool ticks together.
    add(1, 0, 2'b11, 0, 0, 2'b00, 2'b00);
    add(0, 4, 2'b11, 1, 1, 2'b00, 2'b11);
    add(0, 8, 2'b11, 2, 2, 2'b00, 2'b11);
    add(0, 12, 2'b11, 3, 3, 2'b00, 2'b11);
    add(0, 15, 2'b01, 3, 3, 2'b00, 2'b00);
    add(0, 16, 2'b01, 4, 2, 2'b00, 2'b01);
    add(0, 24, 2'b01, 6, 1, 2'b00, 2'b01);
    add(0, 32, 2'b01, 8, 0, 2'b00, 2'b01);
    add(0, 40, 2'b01, 10, 0, 2'b00, 2'b01);

    // Outputs stay cleared while reset is held, even with shoot asserted.
    repeat (3) step();
    expect_out("in_reset", 0, 0, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(3);
      u_if.shoot = vecs[i].shoot;
      while (cyc < vecs[i].cyc) step();
      expect_out($sformatf("vec%0d", i), vecs[i].h0, vecs[i].h1, vecs[i].ovh, vecs[i].pulse);
    end

    // One-cycle reset landing on a shared tick cycle.
    do_reset(3);
    u_if.shoot = 2'b01;
    while (cyc < 111) step();
`ifdef GUN_HEAT_LOCKOUT_EN
    expect_out("pre_midreset", 9, 0, 2'b01, 2'b00);
`else
    expect_out("pre_midreset", 15, 0, 2'b00, 2'b00);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc   = 0;
    expect_out("midreset_clear", 0, 0, 2'b00, 2'b00);
    while (cyc < 3) step();
    expect_out("midreset_c3", 0, 0, 2'b00, 2'b00);
    step();
    expect_out("midreset_c4", 1, 0, 2'b00, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
